fft_frame_sink: RTL

Receives block-floating-point frames from the forward FFT's Avalon-ST source port. It is the consumer end of the FFT streaming interface whose producer end feeds the FFT sink. It checks frame framing (SOP/EOP/length), latches the per-frame block exponent, and normalises each real/imag pair to a fixed scale. Results go into the CPU-side dual-clock FIFO as {real, imag} words. Backpressure is applied from the FIFO fill level.

---
 rtl/fft_stream_pkg.sv | 15 +
 rtl/block_exp_scaler.sv | 28 ++
 rtl/fft_frame_sink.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fft_stream_pkg.sv
// fft_stream_pkg: shared constants, sink state type and exponent-to-shift helper for the FFT stream sink.
package fft_stream_pkg;
   localparam int SAMPLES     = 8192;
   localparam int DATA_W      = 16;
   localparam int EXP_W       = 6;
   localparam int EXP_OFFSET  = 10;
   localparam int SHIFT_W     = 7;
   localparam int IDX_W       = 14;
   localparam int FIFO_DEPTH  = 16384;
   localparam int AFULL_SLACK = 4;
   typedef enum logic [1:0] {IDLE, IN_FRAME, DROP} sink_state_t;
   function automatic logic signed [SHIFT_W-1:0] exp_to_shift(input logic [EXP_W-1:0] e);
      return SHIFT_W'(signed'(e)) + SHIFT_W'(EXP_OFFSET);
   endfunction
endpackage

// File: rtl/block_exp_scaler.sv
// block_exp_scaler: combinational saturating shifter normalising one sample by a signed block shift.
module block_exp_scaler
   import fft_stream_pkg::*;
(
   input  logic signed [DATA_W-1:0]  din,
   input  logic signed [SHIFT_W-1:0] shift,
   output logic        [DATA_W-1:0]  dout
);
   localparam logic [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] NEG_MAX = {1'b1, {(DATA_W-1){1'b0}}};
   logic [SHIFT_W:0] neg;
   logic [SHIFT_W:0] lsh;
   logic signed [DATA_W-1:0] asr;
   logic [2*DATA_W-1:0] wide;
   logic fits;
   always_comb begin
      neg  = -{shift[SHIFT_W-1], shift};
      // Clamping to DATA_W still pushes any nonzero sample out of range, so it saturates correctly.
      lsh  = neg > (SHIFT_W+1)'(DATA_W) ? (SHIFT_W+1)'(DATA_W) : neg;
      asr  = din >>> shift[$clog2(DATA_W)-1:0];
      wide = {{DATA_W{din[DATA_W-1]}}, din} << lsh;
      fits = (&wide[2*DATA_W-1:DATA_W-1]) || !(|wide[2*DATA_W-1:DATA_W-1]);
      dout = shift == '0 ? din :
             !shift[SHIFT_W-1] ? (shift >= SHIFT_W'(DATA_W) ? {DATA_W{din[DATA_W-1]}} : asr) :
             fits ? wide[DATA_W-1:0] :
             din[DATA_W-1] ? NEG_MAX : POS_MAX;
   end
endmodule

// File: rtl/fft_frame_sink.sv
// fft_frame_sink: checks FFT frame framing, latches the block exponent and writes normalised
// {real, imag} words into the CPU-side FIFO with fill-level backpressure.
module fft_frame_sink
   import fft_stream_pkg::*;
(
   input  logic                fft_clk,
   input  logic                reset_n,
   input  logic                src_valid,
   input  logic                src_sop,
   input  logic                src_eop,
   input  logic [DATA_W-1:0]   src_real,
   input  logic [DATA_W-1:0]   src_imag,
   input  logic [EXP_W-1:0]    src_exp,
   output logic                src_ready,
   input  logic [15:0]         fifo_usedw,
   output logic                fifo_wrreq,
   output logic [2*DATA_W-1:0] fifo_data,
   output logic                frame_done,
   output logic [EXP_W-1:0]    frame_exp,
   output logic [15:0]         frame_count,
   output logic [7:0]          err_count
);
   sink_state_t state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic ready_q, ready_d;
   logic wr1_q, wr1_d;
   logic done1_q, done1_d;
   logic wrreq_q, wrreq_d;
   logic done_q, done_d;
   logic [DATA_W-1:0] re1_q, re1_d, im1_q, im1_d;
   logic [DATA_W-1:0] re_s, im_s;
   logic signed [SHIFT_W-1:0] shift1_q, shift1_d;
   logic [2*DATA_W-1:0] data_q, data_d;
   logic [EXP_W-1:0] exp_q, exp_d;
   logic [15:0] fcnt_q, fcnt_d;
   logic [7:0] ecnt_q, ecnt_d;
   logic acc, last, err;

   block_exp_scaler u_scale_re (.din(re1_q), .shift(shift1_q), .dout(re_s));
   block_exp_scaler u_scale_im (.din(im1_q), .shift(shift1_q), .dout(im_s));

   always_comb begin
      acc     = src_valid && ready_q;
      last    = idx_q == IDX_W'(SAMPLES-1);
      state_d = state_q;
      idx_d   = idx_q;
      exp_d   = exp_q;
      fcnt_d  = fcnt_q;
      err     = 1'b0;
      wr1_d   = 1'b0;
      done1_d = 1'b0;
      // A SOP restarts the frame from any state unless it is a lone SOP+EOP outside a frame.
      if (acc && src_sop) begin
         err = state_q == IN_FRAME || src_eop;
         if (state_q == IN_FRAME || !src_eop) begin
            wr1_d   = 1'b1;
            exp_d   = src_exp;
            idx_d   = IDX_W'(1);
            state_d = IN_FRAME;
         end else begin
            state_d = IDLE;
         end
      end else if (acc && state_q == IN_FRAME) begin
         wr1_d = 1'b1;
         if (src_eop) begin
            done1_d = last;
            err     = !last;
            fcnt_d  = fcnt_q + (last ? 16'd1 : 16'd0);
            state_d = IDLE;
         end else if (last) begin
            err     = 1'b1;
            state_d = DROP;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end else if (acc) begin
         err     = state_q == IDLE;
         state_d = src_eop ? IDLE : state_q;
      end
      ecnt_d   = (err && ecnt_q != 8'hFF) ? ecnt_q + 8'd1 : ecnt_q;
      ready_d  = fifo_usedw < 16'(FIFO_DEPTH - AFULL_SLACK);
      re1_d    = src_real;
      im1_d    = src_imag;
      shift1_d = exp_to_shift(src_sop ? src_exp : exp_q);
      wrreq_d  = wr1_q;
      done_d   = done1_q;
      data_d   = wr1_q ? {re_s, im_s} : data_q;
   end

   always_ff @(posedge fft_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         ready_q  <= 1'b0;
         wr1_q    <= 1'b0;
         done1_q  <= 1'b0;
         re1_q    <= '0;
         im1_q    <= '0;
         shift1_q <= '0;
         wrreq_q  <= 1'b0;
         done_q   <= 1'b0;
         data_q   <= '0;
         exp_q    <= '0;
         fcnt_q   <= '0;
         ecnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         ready_q  <= ready_d;
         wr1_q    <= wr1_d;
         done1_q  <= done1_d;
         re1_q    <= re1_d;
         im1_q    <= im1_d;
         shift1_q <= shift1_d;
         wrreq_q  <= wrreq_d;
         done_q   <= done_d;
         data_q   <= data_d;
         exp_q    <= exp_d;
         fcnt_q   <= fcnt_d;
         ecnt_q   <= ecnt_d;
      end
   end

   assign src_ready   = ready_q;
   assign fifo_wrreq  = wrreq_q;
   assign fifo_data   = data_q;
   assign frame_done  = done_q;
   assign frame_exp   = exp_q;
   assign frame_count = fcnt_q;
   assign err_count   = ecnt_q;
endmodule
